// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute sequencer for the 16-bit ISA.
// Fetches the instruction low byte then high byte, executes it in one or two
// cycles, stalls on memory wait states, and flags undefined opcodes.
module control_sequencer #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned REG_ID_W   = 6,
   parameter int unsigned MPTR_OFF_W = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [15:0]           instruction,
   input  logic                  mem_ready,
   input  logic                  flag,
   output logic                  pc_read,
   output logic                  pc_readplusone,
   output logic                  pc_inc,
   output logic                  pc_offset,
   output logic                  ir_write,
   output logic                  ir_writeu,
   output logic                  rf_read,
   output logic                  rf_readu,
   output logic                  rf_write,
   output logic                  rf_writeu,
   output logic [REG_ID_W-1:0]   rf_id,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  mptr_read_abus,
   output logic                  mptr_read_abusplus,
   output logic                  mptr_write,
   output logic                  mptr_writeu,
   output logic [MPTR_OFF_W-1:0] mptr_offset,
   output logic                  alu_write,
   output logic                  alu_writeu,
   output logic [DATA_W-1:0]     dout,
   output logic                  dout_en,
   output logic                  busy,
   output logic                  illegal
);

   typedef enum logic [1:0] {F0, F1, E0, E1} state_t;

   state_t r_state;
   state_t w_next;

   // Instruction fields
   logic [3:0]  w_op;
   logic [3:0]  w_r1;
   logic [7:0]  w_imm8;
   logic [11:0] w_imm12;
   logic [5:0]  w_sub;
   logic [5:0]  w_imm6;

   assign w_op    = instruction[3:0];
   assign w_r1    = instruction[7:4];
   assign w_imm8  = instruction[15:8];
   assign w_imm12 = instruction[15:4];
   assign w_sub   = instruction[9:4];
   assign w_imm6  = instruction[15:10];

   // Extended immediates and offsets
   logic [DATA_W-1:0]     w_sext_imm8;
   logic [DATA_W-1:0]     w_zext_imm8;
   logic [DATA_W-1:0]     w_sext_imm12;
   logic [DATA_W-1:0]     w_zext_imm12;
   logic [DATA_W-1:0]     w_zext_imm6;
   logic [MPTR_OFF_W-1:0] w_sext_off8;
   logic [MPTR_OFF_W-1:0] w_sext_off12;
   logic [REG_ID_W-1:0]   w_rid;

   assign w_sext_imm8  = DATA_W'($signed(w_imm8));
   assign w_zext_imm8  = DATA_W'(w_imm8);
   assign w_sext_imm12 = DATA_W'($signed(w_imm12));
   assign w_zext_imm12 = DATA_W'(w_imm12);
   assign w_zext_imm6  = DATA_W'(w_imm6);
   assign w_sext_off8  = MPTR_OFF_W'($signed(w_imm8));
   assign w_sext_off12 = MPTR_OFF_W'($signed(w_imm12));
   assign w_rid        = REG_ID_W'(w_r1);

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= F0;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state: memory-access states wait for mem_ready before advancing
   always_comb begin
      w_next = r_state;
      case (r_state)
         F0: if (mem_ready) w_next = F1;
         F1: if (mem_ready) w_next = E0;
         E0: begin
            case (w_op)
               4'h2, 4'h3: if (mem_ready) w_next = E1;
               4'h4, 4'h5: if (mem_ready) w_next = F0;
               default:    w_next = F0;
            endcase
         end
         E1: if (mem_ready) w_next = F0;
         default: w_next = F0;
      endcase
   end

   // Output decode of state and instruction; everything low during reset.
   // pc_inc in memory states is gated by mem_ready so it fires only on the
   // cycle that actually completes, while all other outputs hold during a stall.
   always_comb begin
      pc_read            = 1'b0;
      pc_readplusone     = 1'b0;
      pc_inc             = 1'b0;
      pc_offset          = 1'b0;
      ir_write           = 1'b0;
      ir_writeu          = 1'b0;
      rf_read            = 1'b0;
      rf_readu           = 1'b0;
      rf_write           = 1'b0;
      rf_writeu          = 1'b0;
      rf_id              = '0;
      mem_read           = 1'b0;
      mem_write          = 1'b0;
      mptr_read_abus     = 1'b0;
      mptr_read_abusplus = 1'b0;
      mptr_write         = 1'b0;
      mptr_writeu        = 1'b0;
      mptr_offset        = '0;
      alu_write          = 1'b0;
      alu_writeu         = 1'b0;
      dout               = '0;
      dout_en            = 1'b0;
      busy               = 1'b0;
      illegal            = 1'b0;
      if (!reset) begin
         case (r_state)
            F0: begin
               pc_read  = 1'b1;
               mem_read = 1'b1;
               ir_write = 1'b1;
            end
            F1: begin
               busy           = 1'b1;
               pc_readplusone = 1'b1;
               mem_read       = 1'b1;
               ir_writeu      = 1'b1;
            end
            E0: begin
               busy = 1'b1;
               case (w_op)
                  4'h0: begin
                     rf_write = 1'b1;
                     rf_id    = w_rid;
                     dout     = w_sext_imm8;
                     dout_en  = 1'b1;
                     pc_inc   = 1'b1;
                  end
                  4'h1: begin
                     rf_writeu = 1'b1;
                     rf_id     = w_rid;
                     dout      = w_zext_imm8;
                     dout_en   = 1'b1;
                     pc_inc    = 1'b1;
                  end
                  4'h2: begin
                     mptr_read_abus = 1'b1;
                     mem_read       = 1'b1;
                     rf_write       = 1'b1;
                     rf_id          = w_rid;
                  end
                  4'h3: begin
                     mptr_read_abus = 1'b1;
                     mem_write      = 1'b1;
                     rf_read        = 1'b1;
                     rf_id          = w_rid;
                  end
                  4'h4: begin
                     mptr_read_abus = 1'b1;
                     mem_read       = 1'b1;
                     mptr_offset    = w_sext_off8;
                     rf_write       = 1'b1;
                     rf_id          = w_rid;
                     pc_inc         = mem_ready;
                  end
                  4'h5: begin
                     mptr_read_abus = 1'b1;
                     mem_write      = 1'b1;
                     mptr_offset    = w_sext_off8;
                     rf_read        = 1'b1;
                     rf_id          = w_rid;
                     pc_inc         = mem_ready;
                  end
                  4'h6: begin
                     alu_write = 1'b1;
                     dout      = w_sext_imm12;
                     dout_en   = 1'b1;
                     pc_inc    = 1'b1;
                  end
                  4'h7: begin
                     mptr_write = 1'b1;
                     dout       = w_zext_imm12;
                     dout_en    = 1'b1;
                     pc_inc     = 1'b1;
                  end
                  4'h8: begin
                     mptr_writeu = 1'b1;
                     dout        = w_zext_imm12;
                     dout_en     = 1'b1;
                     pc_inc      = 1'b1;
                  end
                  4'h9: begin
                     pc_offset   = 1'b1;
                     mptr_offset = w_sext_off12;
                  end
                  4'hA: begin
                     if (flag) begin
                        pc_offset   = 1'b1;
                        mptr_offset = w_sext_off12;
                     end else begin
                        pc_inc = 1'b1;
                     end
                  end
                  4'hC: begin
                     if (w_sub == 6'b111011) begin
                        alu_writeu = 1'b1;
                        dout       = w_zext_imm6;
                        dout_en    = 1'b1;
                     end else begin
                        illegal = 1'b1;
                     end
                     pc_inc = 1'b1;
                  end
                  default: begin
                     illegal = 1'b1;
                     pc_inc  = 1'b1;
                  end
               endcase
            end
            E1: begin
               busy               = 1'b1;
               mptr_read_abusplus = 1'b1;
               mptr_offset        = w_sext_off8;
               rf_id              = w_rid;
               if (w_op[0]) begin
                  mem_write = 1'b1;
                  rf_readu  = 1'b1;
               end else begin
                  mem_read  = 1'b1;
                  rf_writeu = 1'b1;
               end
               pc_inc = mem_ready;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: a cycle-by-cycle vector table is driven
// after each rising edge; the expected output bundle is pushed to a scoreboard
// and compared on the following falling edge.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instruction;
   logic        mem_ready;
   logic        flag;
   logic        pc_read, pc_readplusone, pc_inc, pc_offset;
   logic        ir_write, ir_writeu;
   logic        rf_read, rf_readu, rf_write, rf_writeu;
   logic [5:0]  rf_id;
   logic        mem_read, mem_write;
   logic        mptr_read_abus, mptr_read_abusplus, mptr_write, mptr_writeu;
   logic [11:0] mptr_offset;
   logic        alu_write, alu_writeu;
   logic [15:0] dout;
   logic        dout_en, busy, illegal;

   always #5 clk = ~clk;

   control_sequencer #(
      .DATA_W(16),
      .REG_ID_W(6),
      .MPTR_OFF_W(12)
   ) dut (
      .clk(clk),
      .reset(reset),
      .instruction(instruction),
      .mem_ready(mem_ready),
      .flag(flag),
      .pc_read(pc_read),
      .pc_readplusone(pc_readplusone),
      .pc_inc(pc_inc),
      .pc_offset(pc_offset),
      .ir_write(ir_write),
      .ir_writeu(ir_writeu),
      .rf_read(rf_read),
      .rf_readu(rf_readu),
      .rf_write(rf_write),
      .rf_writeu(rf_writeu),
      .rf_id(rf_id),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .mptr_read_abus(mptr_read_abus),
      .mptr_read_abusplus(mptr_read_abusplus),
      .mptr_write(mptr_write),
      .mptr_writeu(mptr_writeu),
      .mptr_offset(mptr_offset),
      .alu_write(alu_write),
      .alu_writeu(alu_writeu),
      .dout(dout),
      .dout_en(dout_en),
      .busy(busy),
      .illegal(illegal)
   );

   // One bit per 1-bit control output
   localparam logic [20:0] PRD  = 21'h000001;
   localparam logic [20:0] PRP  = 21'h000002;
   localparam logic [20:0] PINC = 21'h000004;
   localparam logic [20:0] POFF = 21'h000008;
   localparam logic [20:0] IRW  = 21'h000010;
   localparam logic [20:0] IRWU = 21'h000020;
   localparam logic [20:0] RFR  = 21'h000040;
   localparam logic [20:0] RFRU = 21'h000080;
   localparam logic [20:0] RFW  = 21'h000100;
   localparam logic [20:0] RFWU = 21'h000200;
   localparam logic [20:0] MRD  = 21'h000400;
   localparam logic [20:0] MWR  = 21'h000800;
   localparam logic [20:0] MAB  = 21'h001000;
   localparam logic [20:0] MABP = 21'h002000;
   localparam logic [20:0] MW   = 21'h004000;
   localparam logic [20:0] MWU  = 21'h008000;
   localparam logic [20:0] ALW  = 21'h010000;
   localparam logic [20:0] ALWU = 21'h020000;
   localparam logic [20:0] DEN  = 21'h040000;
   localparam logic [20:0] BSY  = 21'h080000;
   localparam logic [20:0] ILL  = 21'h100000;
   localparam logic [20:0] F0M  = PRD | MRD | IRW;
   localparam logic [20:0] F1M  = PRP | MRD | IRWU | BSY;

   logic [20:0] act_ctl;
   assign act_ctl = {illegal, busy, dout_en, alu_writeu, alu_write, mptr_writeu, mptr_write,
                     mptr_read_abusplus, mptr_read_abus, mem_write, mem_read, rf_writeu,
                     rf_write, rf_readu, rf_read, ir_writeu, ir_write, pc_offset, pc_inc,
                     pc_readplusone, pc_read};

   typedef struct {
      int          idx;
      logic        rst;
      logic [15:0] instr;
      logic        mr;
      logic        fl;
      logic [20:0] ctl;
      logic [5:0]  id;
      logic [11:0] moff;
      logic [15:0] dout;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic void add(input logic rst, input logic [15:0] ins, input logic mr,
                               input logic fl, input logic [20:0] ctl, input logic [5:0] id,
                               input logic [11:0] moff, input logic [15:0] d);
      vec_t v;
      v.idx   = vecs.size();
      v.rst   = rst;
      v.instr = ins;
      v.mr    = mr;
      v.fl    = fl;
      v.ctl   = ctl;
      v.id    = id;
      v.moff  = moff;
      v.dout  = d;
      vecs.push_back(v);
   endfunction

   // Scoreboard checker: compare the bundle and two structural invariants
   always @(negedge clk) begin
      vec_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         n_checks++;
         if ({act_ctl, rf_id, mptr_offset, dout} !== {e.ctl, e.id, e.moff, e.dout}) begin
            n_fail++;
            $display("FAIL vec%0d: got ctl=%06h rf_id=%0d moff=%03h dout=%04h, expected ctl=%06h rf_id=%0d moff=%03h dout=%04h",
                     e.idx, act_ctl, rf_id, mptr_offset, dout, e.ctl, e.id, e.moff, e.dout);
         end
         n_checks++;
         if (pc_inc && pc_offset) begin
            n_fail++;
            $display("FAIL pc_excl vec%0d: got pc_inc=%0b pc_offset=%0b, expected not both high",
                     e.idx, pc_inc, pc_offset);
         end
         n_checks++;
         if (!dout_en && dout != 16'h0000) begin
            n_fail++;
            $display("FAIL dout_zero vec%0d: got dout=%04h with dout_en=0, expected 0000", e.idx, dout);
         end
      end
   end

   initial begin
      reset       = 1'b1;
      instruction = 16'h0000;
      mem_ready   = 1'b0;
      flag        = 1'b0;

      // Reset held two cycles while in F1
      add(1, 16'h8010, 1, 0, '0, 0, 0, 0);
      add(0, 16'h8010, 1, 0, F0M, 0, 0, 0);
      add(1, 16'h8010, 1, 0, '0, 0, 0, 0);
      add(1, 16'h8010, 1, 0, '0, 0, 0, 0);
      // LDR r1,0x80
      add(0, 16'h8010, 1, 0, F0M, 0, 0, 0);
      add(0, 16'h8010, 1, 0, F1M, 0, 0, 0);
      add(0, 16'h8010, 1, 0, RFW | PINC | DEN | BSY, 1, 0, 16'hFF80);
      // LD@MPTR r3,5 with two wait cycles in E1
      add(0, 16'h0532, 1, 0, F0M, 0, 0, 0);
      add(0, 16'h0532, 1, 0, F1M, 0, 0, 0);
      add(0, 16'h0532, 1, 0, MAB | MRD | RFW | BSY, 3, 0, 0);
      add(0, 16'h0532, 0, 0, MABP | MRD | RFWU | BSY, 3, 12'h005, 0);
      add(0, 16'h0532, 0, 0, MABP | MRD | RFWU | BSY, 3, 12'h005, 0);
      add(0, 16'h0532, 1, 0, MABP | MRD | RFWU | PINC | BSY, 3, 12'h005, 0);
      // JMPF -2, F0 stall, then taken
      add(0, 16'hFFEA, 0, 1, F0M, 0, 0, 0);
      add(0, 16'hFFEA, 1, 1, F0M, 0, 0, 0);
      add(0, 16'hFFEA, 1, 1, F1M, 0, 0, 0);
      add(0, 16'hFFEA, 1, 1, POFF | BSY, 0, 12'hFFE, 0);
      // JMPF not taken
      add(0, 16'hFFEA, 1, 0, F0M, 0, 0, 0);
      add(0, 16'hFFEA, 1, 0, F1M, 0, 0, 0);
      add(0, 16'hFFEA, 1, 0, PINC | BSY, 0, 0, 0);
      // 0x0B0C: sub 6'b110000 is not LDAU
      add(0, 16'h0B0C, 1, 0, F0M, 0, 0, 0);
      add(0, 16'h0B0C, 1, 0, F1M, 0, 0, 0);
      add(0, 16'h0B0C, 1, 0, ILL | PINC | BSY, 0, 0, 0);
      // 0x0EBC carries sub 6'b101011, so it decodes as illegal too
      add(0, 16'h0EBC, 1, 0, F0M, 0, 0, 0);
      add(0, 16'h0EBC, 1, 0, F1M, 0, 0, 0);
      add(0, 16'h0EBC, 1, 0, ILL | PINC | BSY, 0, 0, 0);
      // 0x0FBC: sub 6'b111011, imm6=3 -> LDAU
      add(0, 16'h0FBC, 1, 0, F0M, 0, 0, 0);
      add(0, 16'h0FBC, 1, 0, F1M, 0, 0, 0);
      add(0, 16'h0FBC, 1, 0, ALWU | DEN | PINC | BSY, 0, 0, 16'h0003);
      // Undefined op 0xB, then back in F0 with busy low
      add(0, 16'h000B, 1, 0, F0M, 0, 0, 0);
      add(0, 16'h000B, 1, 0, F1M, 0, 0, 0);
      add(0, 16'h000B, 1, 0, ILL | PINC | BSY, 0, 0, 0);
      add(0, 16'h000B, 1, 0, F0M, 0, 0, 0);
      add(0, 16'hA541, 1, 0, F1M, 0, 0, 0);
      // LDRU r4,0xA5 (fetched in the two cycles above)
      add(0, 16'hA541, 1, 0, RFWU | PINC | DEN | BSY, 4, 0, 16'h00A5);
      // LDB r2,-3 with one wait cycle in E0
      add(0, 16'hFD24, 1, 0, F0M, 0, 0, 0);
      add(0, 16'hFD24, 1, 0, F1M, 0, 0, 0);
      add(0, 16'hFD24, 0, 0, MAB | MRD | RFW | BSY, 2, 12'hFFD, 0);
      add(0, 16'hFD24, 1, 0, MAB | MRD | RFW | PINC | BSY, 2, 12'hFFD, 0);
      // STB r5,7
      add(0, 16'h0755, 1, 0, F0M, 0, 0, 0);
      add(0, 16'h0755, 1, 0, F1M, 0, 0, 0);
      add(0, 16'h0755, 1, 0, MAB | MWR | RFR | PINC | BSY, 5, 12'h007, 0);
      // LDA 0x812 (sign-extended)
      add(0, 16'h8126, 1, 0, F0M, 0, 0, 0);
      add(0, 16'h8126, 1, 0, F1M, 0, 0, 0);
      add(0, 16'h8126, 1, 0, ALW | DEN | PINC | BSY, 0, 0, 16'hF812);
      // LDMPTR / LDMPTRU 0x812 (zero-extended)
      add(0, 16'h8127, 1, 0, F0M, 0, 0, 0);
      add(0, 16'h8127, 1, 0, F1M, 0, 0, 0);
      add(0, 16'h8127, 1, 0, MW | DEN | PINC | BSY, 0, 0, 16'h0812);
      add(0, 16'h8128, 1, 0, F0M, 0, 0, 0);
      add(0, 16'h8128, 1, 0, F1M, 0, 0, 0);
      add(0, 16'h8128, 1, 0, MWU | DEN | PINC | BSY, 0, 0, 16'h0812);
      // JMP +16, flag ignored
      add(0, 16'h0109, 1, 0, F0M, 0, 0, 0);
      add(0, 16'h0109, 1, 0, F1M, 0, 0, 0);
      add(0, 16'h0109, 1, 0, POFF | BSY, 0, 12'h010, 0);
      // ST@MPTR r6,-1
      add(0, 16'hFF63, 1, 0, F0M, 0, 0, 0);
      add(0, 16'hFF63, 1, 0, F1M, 0, 0, 0);
      add(0, 16'hFF63, 1, 0, MAB | MWR | RFR | BSY, 6, 0, 0);
      add(0, 16'hFF63, 1, 0, MABP | MWR | RFRU | PINC | BSY, 6, 12'hFFF, 0);
      // F1 stall, then reset while stalled in E1
      add(0, 16'h0532, 1, 0, F0M, 0, 0, 0);
      add(0, 16'h0532, 0, 0, F1M, 0, 0, 0);
      add(0, 16'h0532, 1, 0, F1M, 0, 0, 0);
      add(0, 16'h0532, 1, 0, MAB | MRD | RFW | BSY, 3, 0, 0);
      add(0, 16'h0532, 0, 0, MABP | MRD | RFWU | BSY, 3, 12'h005, 0);
      add(1, 16'h0532, 0, 0, '0, 0, 0, 0);
      add(0, 16'h0532, 1, 0, F0M, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk);
         #1;
         reset       = vecs[i].rst;
         instruction = vecs[i].instr;
         mem_ready   = vecs[i].mr;
         flag        = vecs[i].fl;
         sb.push_back(vecs[i]);
      end

      for (int k = 0; k < 8; k++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
